// File: rtl/izh_neuron_array.sv
// Time-multiplexed Izhikevich neuron core: one shared datapath updates N_NEURON (v,u) pairs per timestep.
// Optional clamping of every narrowing to W bits when NEURON_SAT_EN is defined (wraps otherwise).
module izh_neuron_array #(
   parameter int N_NEURON = 4,
   parameter int W        = 21,
   parameter int FRAC     = 10,
   parameter int DT_SHIFT = 4,
   parameter int A_SHIFT  = 6,
   parameter int B_SHIFT  = 2,
   parameter int VTH      = 30 << FRAC,
   parameter int VINIT    = -65 << FRAC,
   parameter int K140     = 140 << FRAC,
   localparam int IDXW    = (N_NEURON > 1) ? $clog2(N_NEURON) : 1
) (
   input  logic                  clk,
   input  logic                  set_n,
   input  logic                  start,
   input  logic [N_NEURON*W-1:0] I_bus,
   input  logic [W-1:0]          c,
   input  logic [W-1:0]          d,
   output logic                  busy,
   output logic                  done,
   output logic [N_NEURON-1:0]   spike_vec,
   input  logic [IDXW-1:0]       rd_idx,
   output logic [W-1:0]          rd_v,
   output logic [W-1:0]          rd_u
);
   localparam int IW = 2*W + 2;
   localparam logic signed [W-1:0]  VTH_W   = W'(VTH);
   localparam logic signed [W-1:0]  VINIT_W = W'(VINIT);
   localparam logic signed [W-1:0]  UINIT_W = VINIT_W >>> B_SHIFT;
   localparam logic signed [IW-1:0] K140E   = IW'(K140);

   typedef enum logic [2:0] {IDLE, READ, MUL, CALC, WRITE, DONE} state_t;

   state_t state, state_nxt;
   logic [IDXW-1:0]          idx;
   logic signed [W-1:0]      v_mem [N_NEURON];
   logic signed [W-1:0]      u_mem [N_NEURON];
   logic [N_NEURON*W-1:0]    i_lat;
   logic signed [W-1:0]      c_lat, d_lat, vr, ur, vn, un, i_cur;
   logic signed [2*W-1:0]    q, vx, sq;
   logic signed [IW-1:0]     qe, ve, ue, ie, une, de, dv, du, vn_w, un_w, ud_w;
   logic [N_NEURON-1:0]      spk_acc, spk_new;
   logic                     last, spike_now;

   function automatic logic signed [W-1:0] narrow(input logic signed [IW-1:0] x);
`ifdef NEURON_SAT_EN
      logic signed [W-1:0]  smax, smin;
      logic signed [IW-1:0] hi, lo;
      smax = {1'b0, {(W-1){1'b1}}};
      smin = {1'b1, {(W-1){1'b0}}};
      hi = smax;
      lo = smin;
      if (x > hi)      return smax;
      else if (x < lo) return smin;
      else             return W'(x);
`else
      return W'(x);
`endif
   endfunction

   // Sequencing: four cycles per neuron, then a single DONE cycle
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = READ;
         READ:    state_nxt = MUL;
         MUL:     state_nxt = CALC;
         CALC:    state_nxt = WRITE;
         WRITE:   state_nxt = last ? DONE : READ;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);
   assign last = (idx == IDXW'(N_NEURON - 1));

   always_ff @(posedge clk or negedge set_n) begin
      if (!set_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Euler update in 2W+2 bits so the quadratic term cannot overflow before narrowing
   always_comb begin
      vx    = vr;
      sq    = vx * vx;
      qe    = q;
      ve    = vr;
      ue    = ur;
      i_cur = $signed(i_lat[idx*W +: W]);
      ie    = i_cur;
      dv    = (qe >>> 5) + (qe >>> 7) + (qe >>> 9) + (ve <<< 2) + ve + K140E - ue + ie;
      du    = ((ve >>> B_SHIFT) - ue) >>> A_SHIFT;
      vn_w  = ve + (dv >>> DT_SHIFT);
      un_w  = ue + (du >>> DT_SHIFT);
      une   = un;
      de    = d_lat;
      ud_w  = une + de;
      spike_now    = (vn >= VTH_W);
      spk_new      = spk_acc;
      spk_new[idx] = spike_now;
   end

   always_ff @(posedge clk or negedge set_n) begin
      if (!set_n) begin
         for (int k = 0; k < N_NEURON; k++) begin
            v_mem[k] <= VINIT_W;
            u_mem[k] <= UINIT_W;
         end
         idx       <= '0;
         i_lat     <= '0;
         c_lat     <= '0;
         d_lat     <= '0;
         vr        <= '0;
         ur        <= '0;
         q         <= '0;
         vn        <= '0;
         un        <= '0;
         spk_acc   <= '0;
         spike_vec <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               i_lat <= I_bus;
               c_lat <= c;
               d_lat <= d;
               idx   <= '0;
            end
            READ: begin
               vr <= v_mem[idx];
               ur <= u_mem[idx];
            end
            MUL:  q <= sq >>> FRAC;
            CALC: begin
               vn <= narrow(vn_w);
               un <= narrow(un_w);
            end
            WRITE: begin
               if (spike_now) begin
                  v_mem[idx] <= c_lat;
                  u_mem[idx] <= narrow(ud_w);
               end else begin
                  v_mem[idx] <= vn;
                  u_mem[idx] <= un;
               end
               spk_acc <= spk_new;
               if (last) spike_vec <= spk_new;
               else      idx <= idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign rd_v = v_mem[rd_idx];
   assign rd_u = u_mem[rd_idx];
endmodule

// File: tb/tb_izh_neuron_array.sv
// Scoreboard bench for izh_neuron_array: an arithmetic reference model predicts every timestep,
// a monitor compares spikes and read-back state whenever done pulses.
module tb_izh_neuron_array;
   localparam int N = 4;
   localparam int W = 21;
   localparam longint VTH   = 30 <<< 10;
   localparam longint VINIT = -65 * 1024;
   localparam longint K140  = 140 <<< 10;

   logic clk = 1'b0;
   logic set_n, start;
   logic [N*W-1:0] I_bus;
   logic [W-1:0] c, d, rd_v, rd_u;
   logic busy, done;
   logic [N-1:0] spike_vec;
   logic [1:0] rd_idx;

   always #5 clk = ~clk;

   izh_neuron_array dut (
      .clk(clk), .set_n(set_n), .start(start), .I_bus(I_bus), .c(c), .d(d),
      .busy(busy), .done(done), .spike_vec(spike_vec),
      .rd_idx(rd_idx), .rd_v(rd_v), .rd_u(rd_u)
   );

   typedef struct packed {
      logic [N-1:0]   spk;
      logic [N*W-1:0] v;
      logic [N*W-1:0] u;
   } exp_t;

   exp_t   sbq[$];
   longint mV[N], mU[N];
   int     vectors = 0, miscompares = 0;
   int     reqCnt = 0, ackCnt = 0;

   function automatic longint nar(input longint x);
      logic [W-1:0] t;
`ifdef NEURON_SAT_EN
      longint hi, lo;
      hi = (longint'(1) <<< (W-1)) - 1;
      lo = -(longint'(1) <<< (W-1));
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
`else
      t = x[W-1:0];
      return longint'($signed(t));
`endif
   endfunction

   task automatic checkOutput(input string name, input longint act, input longint expv);
      vectors++;
      if (act != expv) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   task automatic modelReset();
      for (int k = 0; k < N; k++) begin
         mV[k] = VINIT;
         mU[k] = VINIT >>> 2;
      end
   endtask

   // Izhikevich Euler step with v' = 0.04v^2 + 5v + 140 - u + I, a = 1/64, b = 1/4, dt = 1/16
   task automatic modelStep(input logic [N*W-1:0] ib, input longint cc, input longint dd,
                            output logic [N-1:0] spk);
      longint v, u, q, dv, du, vn, un, ik;
      logic [W-1:0] s;
      for (int k = 0; k < N; k++) begin
         v  = mV[k];
         u  = mU[k];
         s  = ib[k*W +: W];
         ik = longint'($signed(s));
         q  = (v * v) >>> 10;
         dv = (q >>> 5) + (q >>> 7) + (q >>> 9) + 5 * v + K140 - u + ik;
         du = ((v >>> 2) - u) >>> 6;
         vn = nar(v + (dv >>> 4));
         un = nar(u + (du >>> 4));
         spk[k] = (vn >= VTH);
         if (spk[k]) begin
            mV[k] = cc;
            mU[k] = nar(un + dd);
         end else begin
            mV[k] = vn;
            mU[k] = un;
         end
      end
   endtask

   task automatic pushExpect(input logic [N-1:0] spk);
      exp_t   e;
      longint t;
      e.spk = spk;
      for (int k = 0; k < N; k++) begin
         t = mV[k];
         e.v[k*W +: W] = t[W-1:0];
         t = mU[k];
         e.u[k*W +: W] = t[W-1:0];
      end
      sbq.push_back(e);
   endtask

   // Monitor: owns rd_idx; checks a popped expectation on done, or the model state on request
   initial begin
      exp_t e;
      logic [W-1:0] tv;
      rd_idx = '0;
      forever begin
         @(negedge clk);
         if (set_n && done) begin
            if (sbq.size() == 0) begin
               checkOutput("unexpected_done", 1, 0);
            end else begin
               e = sbq.pop_front();
               checkOutput("spike_vec", longint'(spike_vec), longint'(e.spk));
               for (int k = 0; k < N; k++) begin
                  rd_idx = 2'(k);
                  #1;
                  tv = e.v[k*W +: W];
                  checkOutput("rd_v", longint'($signed(rd_v)), longint'($signed(tv)));
                  tv = e.u[k*W +: W];
                  checkOutput("rd_u", longint'($signed(rd_u)), longint'($signed(tv)));
               end
            end
         end else if (ackCnt < reqCnt) begin
            for (int k = 0; k < N; k++) begin
               rd_idx = 2'(k);
               #1;
               checkOutput("state_v", longint'($signed(rd_v)), mV[k]);
               checkOutput("state_u", longint'($signed(rd_u)), mU[k]);
            end
            ackCnt++;
         end
      end
   end

   task automatic requestStateCheck();
      reqCnt++;
      for (int i = 0; i < 10 && ackCnt < reqCnt; i++) @(negedge clk);
      if (ackCnt < reqCnt) checkOutput("state_check_timeout", 0, 1);
   endtask

   // One timestep: optional extra start while busy, optional start during done, optional reset abort
   task automatic applyStimulus(input logic [N*W-1:0] ib, input longint cc, input longint dd,
                                input int extraAt, input bit startOnDone, input int resetAt,
                                output logic [N-1:0] dutSpk);
      logic [N-1:0] spk;
      bit finished = 0;
      @(negedge clk);
      I_bus = ib;
      c     = cc[W-1:0];
      d     = dd[W-1:0];
      start = 1'b1;
      modelStep(ib, cc, dd, spk);
      pushExpect(spk);
      dutSpk = '0;
      for (int n = 1; n <= 40 && !finished; n++) begin
         @(negedge clk);
         start = (n == extraAt);
         if (n == 1) checkOutput("busy_start", busy, 1);
         if (n == resetAt) begin
            set_n = 1'b0;
            #1;
            checkOutput("abort_busy", busy, 0);
            checkOutput("abort_done", done, 0);
            checkOutput("abort_spike_vec", longint'(spike_vec), 0);
            void'(sbq.pop_back());
            modelReset();
            @(negedge clk);
            set_n = 1'b1;
            requestStateCheck();
            finished = 1;
         end else if (done) begin
            checkOutput("done_cycle", n, 4 * N + 1);
            checkOutput("busy_in_done", busy, 1);
            dutSpk = spike_vec;
            if (startOnDone) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            checkOutput("idle_after_done", busy, 0);
            finished = 1;
         end
      end
      if (!finished) checkOutput("done_timeout", 0, 1);
      start = 1'b0;
   endtask

   initial begin
      logic [N-1:0] dutSpk;
      logic [N*W-1:0] ib;
      bit spiked;
      set_n = 1'b0;
      start = 1'b0;
      I_bus = '0;
      c = '0;
      d = '0;
      modelReset();
      repeat (3) @(negedge clk);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_spike_vec", longint'(spike_vec), 0);
      set_n = 1'b1;
      requestStateCheck();

      $display("[TB] rest step");
      applyStimulus('0, VINIT, 8192, 0, 0, 0, dutSpk);

      $display("[TB] busy rejection and start during done");
      applyStimulus('0, VINIT, 8192, 5, 1, 0, dutSpk);

      $display("[TB] drive neuron 2");
      ib = '0;
      ib[2*W +: W] = W'(102400);
      spiked = 0;
      for (int s = 0; s < 40 && !spiked; s++) begin
         applyStimulus(ib, VINIT, 8192, 0, 0, 0, dutSpk);
         if (dutSpk[2]) spiked = 1;
      end
      checkOutput("drive_spiked", spiked, 1);
      checkOutput("drive_others", longint'(dutSpk & 4'b1011), 0);

      $display("[TB] async reset mid-step");
      applyStimulus(ib, VINIT, 8192, 0, 0, 7, dutSpk);

      $display("[TB] random steps");
      for (int s = 0; s < 12; s++) begin
         for (int k = 0; k < N; k++) ib[k*W +: W] = W'($urandom_range(0, 150 * 1024));
         applyStimulus(ib, -longint'($urandom_range(50 * 1024, 70 * 1024)),
                       longint'($urandom_range(0, 10 * 1024)), 0, 0, 0, dutSpk);
      end

      $display("[TB] saturation");
      for (int k = 0; k < N; k++) ib[k*W +: W] = W'(1048575);
      for (int s = 0; s < 6; s++) applyStimulus(ib, 30720, 1048575, 0, 0, 0, dutSpk);

      repeat (3) @(negedge clk);
      checkOutput("scoreboard_empty", sbq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
